// File: rtl/esn_pkg.sv
// rtl/esn_pkg.sv - shared FSM states, Q-format constants and saturation helper for the ESN readout
package esn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_RES,
        S_UPD,
        S_OUT
    } state_t;

    localparam int XFRAC = 15;
    localparam int WFRAC = 16;

    // Clamp a wide signed value into the signed range of a ww-bit word.
    function automatic logic signed [63:0] sat_to_ww(input logic signed [63:0] v, input int ww);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ww - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ww - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/esn_lms_readout_if.sv
// rtl/esn_lms_readout_if.sv - input and output valid/ready streams of the ESN readout
interface esn_lms_readout_if #(
    parameter int N_X = 8,
    parameter int XW  = 16,
    parameter int WW  = 32
) ();
    logic                in_valid;
    logic                in_ready;
    logic [N_X*XW-1:0]   xstate;
    logic [WW-1:0]       target;
    logic                train;
    logic                out_valid;
    logic                out_ready;
    logic [WW-1:0]       est;
    logic [WW-1:0]       err;

    modport master (
        output in_valid, xstate, target, train, out_ready,
        input  in_ready, out_valid, est, err
    );

    modport slave (
        input  in_valid, xstate, target, train, out_ready,
        output in_ready, out_valid, est, err
    );
endinterface

// File: rtl/esn_sat_mac.sv
// rtl/esn_sat_mac.sv - combinational multiply, arithmetic shift and saturating add
module esn_sat_mac
    import esn_pkg::*;
#(
    parameter int XW       = 16,
    parameter int WW       = 32,
    parameter int MU_SHIFT = 8
) (
    input  logic signed [WW-1:0] coef,
    input  logic signed [XW-1:0] x,
    input  logic signed [WW-1:0] base,
    input  logic                 upd,
    output logic signed [WW-1:0] sum
);
    localparam int PW = XW + WW;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic signed [63:0]   total;
    logic signed [63:0]   clamped;

    // MAC scales the product back to Q16.16; UPD additionally applies the LMS step.
    always_comb begin
        prod    = coef * x;
        shifted = upd ? (prod >>> (XFRAC + MU_SHIFT)) : (prod >>> XFRAC);
        total   = 64'(shifted) + 64'(base);
        clamped = sat_to_ww(total, WW);
        sum     = clamped[WW-1:0];
    end
endmodule

// File: rtl/esn_lms_readout.sv
// rtl/esn_lms_readout.sv - serial ESN readout with LMS training; ESN_READOUT_BIAS_EN adds a bias weight
module esn_lms_readout
    import esn_pkg::*;
#(
    parameter int N_X      = 8,
    parameter int XW       = 16,
    parameter int WW       = 32,
    parameter int MU_SHIFT = 8,
`ifdef ESN_READOUT_BIAS_EN
    localparam int NW      = N_X + 1
`else
    localparam int NW      = N_X
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    esn_lms_readout_if.slave     bus,
    input  logic                 clear_w,
    output logic [NW*WW-1:0]     w_out,
    output logic                 busy
);
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    state_t                state;
    logic signed [WW-1:0]  w [NW];
    logic signed [WW-1:0]  acc;
    logic [IW-1:0]         idx;
    logic [N_X*XW-1:0]     xreg;
    logic signed [WW-1:0]  tgt;
    logic                  trn;
    logic signed [WW-1:0]  est_r;
    logic signed [WW-1:0]  err_r;
    logic                  out_valid_r;

    logic signed [XW-1:0]  xs [NW];
    logic signed [WW-1:0]  mac_sum;
    logic signed [63:0]    diff;
    logic                  last;

    always_comb begin
        for (int i = 0; i < N_X; i++)
            xs[i] = xreg[i*XW +: XW];
`ifdef ESN_READOUT_BIAS_EN
        xs[N_X] = {1'b0, {(XW-1){1'b1}}};
`endif
        for (int i = 0; i < NW; i++)
            w_out[i*WW +: WW] = w[i];
        diff = sat_to_ww(64'(tgt) - 64'(acc), WW);
        last = (idx == IW'(NW - 1));
    end

    // One arithmetic unit: MAC uses (W, acc), UPD uses (err, W) on the same idx.
    esn_sat_mac #(.XW(XW), .WW(WW), .MU_SHIFT(MU_SHIFT)) u_mac (
        .coef (state == S_UPD ? err_r : w[idx]),
        .x    (xs[idx]),
        .base (state == S_UPD ? w[idx] : acc),
        .upd  (state == S_UPD),
        .sum  (mac_sum)
    );

    assign bus.in_ready  = (state == S_IDLE) && !clear_w;
    assign bus.out_valid = out_valid_r;
    assign bus.est       = est_r;
    assign bus.err       = err_r;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            for (int i = 0; i < NW; i++)
                w[i] <= '0;
            acc         <= '0;
            idx         <= '0;
            xreg        <= '0;
            tgt         <= '0;
            trn         <= 1'b0;
            est_r       <= '0;
            err_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear_w) begin
                        for (int i = 0; i < NW; i++)
                            w[i] <= '0;
                    end else if (bus.in_valid) begin
                        xreg  <= bus.xstate;
                        tgt   <= bus.target;
                        trn   <= bus.train;
                        acc   <= '0;
                        idx   <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= mac_sum;
                    if (last) begin
                        idx   <= '0;
                        state <= S_RES;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_RES: begin
                    est_r <= acc;
                    err_r <= diff[WW-1:0];
                    if (trn) begin
                        state <= S_UPD;
                    end else begin
                        out_valid_r <= 1'b1;
                        state       <= S_OUT;
                    end
                end
                S_UPD: begin
                    w[idx] <= mac_sum;
                    if (last) begin
                        idx         <= '0;
                        out_valid_r <= 1'b1;
                        state       <= S_OUT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
